// File: rtl/serial_sub8.sv
// Bit-serial two's-complement subtractor O = I0 - I1, one bit per clock, LSB first.
// Optional signed-overflow output V is enabled by defining SERIAL_SUB_OVF_EN.
`timescale 1ns/1ps
module serial_sub8 #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] O,
  output logic             BOUT,
  output logic             OUT_VALID,
  input  logic             OUT_READY
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             V
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, o_q, o_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             borrow_q, borrow_d, bout_q, bout_d;
  logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic             diff_bit_s, borrow_nxt_s;
`ifdef SERIAL_SUB_OVF_EN
  logic             sign_a_q, sign_a_d, sign_b_q, sign_b_d, v_q, v_d;
`endif

  // Full-subtractor cell on the current LSBs plus FSM next-state and datapath.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    r_d         = r_q;
    o_d         = o_q;
    cnt_d       = cnt_q;
    borrow_d    = borrow_q;
    bout_d      = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    sign_a_d    = sign_a_q;
    sign_b_d    = sign_b_q;
    v_d         = v_q;
`endif
    diff_bit_s   = a_q[0] ^ b_q[0] ^ borrow_q;
    borrow_nxt_s = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & borrow_q);

    case (state_q)
      IDLE: begin
        if (IN_VALID) begin
          a_d      = I0;
          b_d      = I1;
          borrow_d = 1'b0;
          cnt_d    = {CW{1'b0}};
`ifdef SERIAL_SUB_OVF_EN
          sign_a_d = I0[WIDTH-1];
          sign_b_d = I1[WIDTH-1];
`endif
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        r_d      = {diff_bit_s, r_q[WIDTH-1:1]};
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        borrow_d = borrow_nxt_s;
        cnt_d    = cnt_q + CW'(1);
        // The final cell emits the MSB, so the result is complete this edge.
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          o_d     = r_d;
          bout_d  = borrow_nxt_s;
`ifdef SERIAL_SUB_OVF_EN
          v_d     = (sign_a_q != sign_b_q) & (diff_bit_s != sign_a_q);
`endif
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (OUT_READY) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      a_q         <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      r_q         <= {WIDTH{1'b0}};
      o_q         <= {WIDTH{1'b0}};
      cnt_q       <= {CW{1'b0}};
      borrow_q    <= 1'b0;
      bout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      v_q         <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      r_q         <= r_d;
      o_q         <= o_d;
      cnt_q       <= cnt_d;
      borrow_q    <= borrow_d;
      bout_q      <= bout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef SERIAL_SUB_OVF_EN
      sign_a_q    <= sign_a_d;
      sign_b_q    <= sign_b_d;
      v_q         <= v_d;
`endif
    end
  end

  assign IN_READY  = in_ready_q;
  assign OUT_VALID = out_valid_q;
  assign O         = o_q;
  assign BOUT      = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign V         = v_q;
`endif

endmodule
